// File: rtl/multicycle_ctrl_if.sv
// Instruction-memory fetch channel: a request (valid/ready with address)
// and a one-cycle response pulse carrying the fetched word.
interface multicycle_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with halt on ebreak,
// traps on illegal opcode or fetch timeout, and a retired-instruction counter.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_ctrl_if.master        imem,
    output logic [31:0]              inst,
    output logic [31:0]              pc,
    output logic                     reg_write_en,
    output logic [31:0]              retired,
    output logic                     halted,
    output logic                     error,
    output logic [1:0]               err_cause
);

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;
    localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            retired_q <= '0;
            cnt_q     <= '0;
            cause_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        case (state_q)
            S_FETCH_REQ: begin
                // req_valid is unconditionally high here, so ready alone accepts.
                if (imem.req_ready) begin
                    state_d = S_FETCH_WAIT;
                    cnt_d   = '0;
                end
            end
            S_FETCH_WAIT: begin
                // A response on the final timeout cycle takes priority over the trap.
                if (imem.rsp_valid) begin
                    inst_d  = imem.rsp_data;
                    state_d = S_DECODE;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    state_d = S_ERROR;
                    cause_d = 2'd2;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (inst_q == EBREAK_INST) begin
                    state_d = S_HALT;
                end else if (inst_q[6:0] == OPC_OP_IMM) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_ERROR;
                    cause_d = 2'd1;
                end
            end
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                pc_d      = pc_q + 32'd4;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH_REQ;
            end
            default: ;
        endcase
    end

    always_comb begin
        imem.req_valid = (state_q == S_FETCH_REQ);
        imem.req_addr  = pc_q;
        reg_write_en   = (state_q == S_WRITEBACK);
        halted         = (state_q == S_HALT);
        error          = (state_q == S_ERROR);
    end

    assign inst      = inst_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign err_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-memory driver plus a per-instruction
// model of expected PC, retire count, write pulses and cycle cost.
module tb_multicycle_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst, pc, retired;
    logic        reg_write_en, halted, error;
    logic [1:0]  err_cause;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (bus),
        .inst         (inst),
        .pc           (pc),
        .reg_write_en (reg_write_en),
        .retired      (retired),
        .halted       (halted),
        .error        (error),
        .err_cause    (err_cause)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int wr_pulses = 0;
    int exp_pulses = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;

    always @(posedge clk) if (reg_write_en === 1'b1) wr_pulses <= wr_pulses + 1;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 1;
        exp_pc = RESET_PC;
        exp_retired = 0;
    endtask

    function automatic logic [31:0] rand_addi();
        return {$urandom() & 32'hFFFF_FF80} | 32'h13;
    endfunction

    // Drives one fetch with given request stall and response delay; ends in DECODE.
    task automatic fetch(input logic [31:0] word, input int stall, input int delay);
        for (int i = 0; i <= stall; i++) begin
            vectors++;
            if (bus.req_valid !== 1'b1 || bus.req_addr !== exp_pc) begin
                miscompares++;
                $display("FAIL req_hold valid=%0b addr=%h expected valid=1 addr=%h",
                         bus.req_valid, bus.req_addr, exp_pc);
            end
            bus.req_ready = (i == stall);
            step();
        end
        bus.req_ready = 1'b0;
        vectors++;
        if (bus.req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop valid=%0b expected 0", bus.req_valid);
        end
        for (int j = 0; j < delay; j++) step();
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = word;
        step();
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = $urandom();
        vectors++;
        if (inst !== word) begin
            miscompares++;
            $display("FAIL inst_load got %h expected %h", inst, word);
        end
    endtask

    task automatic run_instr(input logic [31:0] word, input int stall, input int delay,
                             output int wb_cyc);
        int start;
        start = cyc;
        fetch(word, stall, delay);
        step();
        step();
        vectors++;
        if (reg_write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL wb_strobe got %0b expected 1", reg_write_en);
        end
        wb_cyc = cyc;
        step();
        exp_pc = exp_pc + 32'd4;
        exp_retired = exp_retired + 32'd1;
        exp_pulses++;
        vectors++;
        if (pc !== exp_pc || retired !== exp_retired || inst !== word) begin
            miscompares++;
            $display("FAIL retire pc=%h ret=%0d inst=%h expected pc=%h ret=%0d inst=%h",
                     pc, retired, inst, exp_pc, exp_retired, word);
        end
        vectors++;
        if (cyc - start != 5 + stall + delay || wr_pulses != exp_pulses) begin
            miscompares++;
            $display("FAIL latency cycles=%0d pulses=%0d expected cycles=%0d pulses=%0d",
                     cyc - start, wr_pulses, 5 + stall + delay, exp_pulses);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (pc !== RESET_PC || inst !== NOP || retired !== 0 || halted !== 0 ||
            error !== 0 || err_cause !== 0 || reg_write_en !== 0) begin
            miscompares++;
            $display("FAIL reset pc=%h inst=%h ret=%0d h=%0b e=%0b c=%0d we=%0b expected %h %h 0 0 0 0 0",
                     pc, inst, retired, halted, error, err_cause, reg_write_en, RESET_PC, NOP);
        end
    endtask

    task automatic test_zero_wait();
        int wb [3];
        apply_reset();
        for (int k = 0; k < 3; k++) run_instr(rand_addi(), 0, 0, wb[k]);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (wb[k] != 5 * (k + 1)) begin
                miscompares++;
                $display("FAIL wb_cycle[%0d] got %0d expected %0d", k, wb[k], 5 * (k + 1));
            end
        end
        vectors++;
        if (retired !== 32'd3) begin
            miscompares++;
            $display("FAIL retired3 got %0d expected 3", retired);
        end
    endtask

    task automatic test_stall();
        int wb;
        apply_reset();
        run_instr(rand_addi(), 4, 0, wb);
    endtask

    task automatic test_halt();
        int wb;
        apply_reset();
        run_instr(rand_addi(), 0, 1, wb);
        fetch(32'h0010_0073, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (halted !== 1'b1 || error !== 1'b0 || retired !== exp_retired ||
                bus.req_valid !== 1'b0 || pc !== exp_pc || wr_pulses != exp_pulses) begin
                miscompares++;
                $display("FAIL halt h=%0b e=%0b ret=%0d rv=%0b pc=%h pulses=%0d expected 1 0 %0d 0 %h %0d",
                         halted, error, retired, bus.req_valid, pc, wr_pulses,
                         exp_retired, exp_pc, exp_pulses);
            end
            step();
        end
    endtask

    task automatic test_illegal();
        int wb;
        apply_reset();
        run_instr(rand_addi(), 1, 0, wb);
        fetch(32'h0000_0033, 0, 2);
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (error !== 1'b1 || halted !== 1'b0 || err_cause !== 2'd1 || pc !== exp_pc ||
                inst !== 32'h0000_0033 || bus.req_valid !== 1'b0 || wr_pulses != exp_pulses) begin
                miscompares++;
                $display("FAIL illegal e=%0b h=%0b c=%0d pc=%h inst=%h rv=%0b expected 1 0 1 %h 00000033 0",
                         error, halted, err_cause, pc, inst, bus.req_valid, exp_pc);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        int wb;
        apply_reset();
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early error=%0b after 3 wait cycles expected 0", error);
        end
        step();
        vectors++;
        if (error !== 1'b1 || err_cause !== 2'd2 || pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL timeout e=%0b c=%0d pc=%h expected 1 2 %h", error, err_cause, pc, RESET_PC);
        end
        apply_reset();
        run_instr(rand_addi(), 0, 3, wb);
        vectors++;
        if (error !== 1'b0 || err_cause !== 2'd0) begin
            miscompares++;
            $display("FAIL late_rsp e=%0b c=%0d expected 0 0", error, err_cause);
        end
    endtask

    task automatic test_reset_stale();
        int wb;
        logic [31:0] w;
        apply_reset();
        run_instr(rand_addi(), 0, 0, wb);
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pc = RESET_PC;
        exp_retired = 0;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hDEAD_BEEF;
        step();
        bus.rsp_valid = 1'b0;
        vectors++;
        if (pc !== RESET_PC || retired !== 0 || inst !== NOP || bus.req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stale pc=%h ret=%0d inst=%h rv=%0b expected %h 0 %h 1",
                     pc, retired, inst, bus.req_valid, RESET_PC, NOP);
        end
        w = rand_addi();
        run_instr(w, 2, 3, wb);
    endtask

    task automatic test_random();
        int wb;
        apply_reset();
        for (int k = 0; k < 25; k++)
            run_instr(rand_addi(), $urandom_range(0, 3), $urandom_range(0, 3), wb);
    endtask

    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_halt();
        test_illegal();
        test_timeout();
        test_reset_stale();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
